// File: rtl/rptr_level_empty.sv
// Read-side pointer and status generator for the FIFO family.
// Holds the binary read address and Gray read pointer, and produces registered
// empty, fill-level and almost-empty status from the synchronized Gray write
// pointer. The sticky underflow flag is built only when RPTR_LEVEL_UNDERFLOW_EN
// is defined; otherwise runderflow is tied low and rclr_uf is ignored.
module rptr_level_empty #(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   rae_thresh,
  input  logic                rclr_uf,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              rae_q, rae_d;
  logic [ADDRSIZE:0] wbin;
  logic              rd_en;

  // A read only advances the pointer when the FIFO is not empty.
  assign rd_en = rinc & ~rempty_q;

  // Gray-to-binary conversion of the synchronized write pointer (prefix XOR from MSB).
  always_comb begin
    wbin           = '0;
    wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
  end

  // Next-state pointer and status computation.
  always_comb begin
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rptr_d == rq2_wptr);
    // Modular difference stays correct across pointer wrap.
    rlevel_d = wbin - rbin_d;
    rae_d    = (rlevel_d <= rae_thresh);
  end

  // Pointer and status registers with synchronous reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
      rae_q    <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rlevel_q <= rlevel_d;
      rae_q    <= rae_d;
    end
  end

`ifdef RPTR_LEVEL_UNDERFLOW_EN
  logic uf_q;

  // Sticky underflow: a read attempt while empty sets it; set beats clear.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      uf_q <= 1'b0;
    end else if (rinc && rempty_q) begin
      uf_q <= 1'b1;
    end else if (rclr_uf) begin
      uf_q <= 1'b0;
    end
  end

  assign runderflow = uf_q;
`else
  logic unused_rclr_uf;
  assign unused_rclr_uf = rclr_uf;
  assign runderflow     = 1'b0;
`endif

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign rlevel        = rlevel_q;
  assign ralmost_empty = rae_q;

endmodule

// File: tb/tb_rptr_level_empty.sv
// Self-checking bench for rptr_level_empty (ADDRSIZE = 4).
// A count-based model (read count, write count, modular level) predicts every
// output each cycle; directed literal checks pin the model at key points.
module tb_rptr_level_empty;

  localparam int AW = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rae_thresh;
  logic          rclr_uf;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   rlevel;
  logic          runderflow;

  int n_checks = 0;
  int n_errors = 0;
  int w_cnt    = 0;

  rptr_level_empty #(.ADDRSIZE(AW)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rae_thresh    (rae_thresh),
    .rclr_uf       (rclr_uf),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  assign rq2_wptr = gray5(w_cnt);

`ifdef RPTR_LEVEL_UNDERFLOW_EN
  localparam bit UfEn = 1'b1;
`else
  localparam bit UfEn = 1'b0;
`endif

  // Model state: number of words read so far (mod 32) and derived status.
  int m_r     = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_ae    = 1'b1;
  bit m_uf    = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge rclk) begin
    if (rrst) begin
      m_r = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      bit attempt_empty;
      attempt_empty = rinc && m_empty;
      if (rinc && !m_empty) m_r = (m_r + 1) % 32;
      m_level = (((w_cnt % 32) - m_r) % 32 + 32) % 32;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= int'(rae_thresh));
      if (UfEn) begin
        if (attempt_empty) m_uf = 1'b1;
        else if (rclr_uf)  m_uf = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge rclk) begin
    if (m_valid) begin
      chk("m_raddr",  32'(raddr),         32'(m_r % 16));
      chk("m_rptr",   32'(rptr),          32'(gray5(m_r)));
      chk("m_rempty", 32'(rempty),        32'(m_empty));
      chk("m_rlevel", 32'(rlevel),        32'(m_level));
      chk("m_rae",    32'(ralmost_empty), 32'(m_ae));
      chk("m_uf",     32'(runderflow),    32'(m_uf));
    end
  end

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    // Reset with rinc and rclr_uf asserted.
    rrst = 1'b1; rinc = 1'b1; rclr_uf = 1'b1; rae_thresh = 5'd2; w_cnt = 0;
    cyc();
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_rptr", 32'(rptr), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_rae", 32'(ralmost_empty), 1);
    chk("rst_rlevel", 32'(rlevel), 0);
    chk("rst_uf", 32'(runderflow), 0);

    // Fill: write pointer at 5.
    rrst = 1'b0; rinc = 1'b0; rclr_uf = 1'b0; w_cnt = 5;
    cyc();
    chk("fill_rempty", 32'(rempty), 0);
    chk("fill_rlevel", 32'(rlevel), 5);
    chk("fill_rae", 32'(ralmost_empty), 0);

    // Drain five words.
    rinc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("drain_rlevel", 32'(rlevel), 32'(5 - i));
      chk("drain_rae", 32'(ralmost_empty), (5 - i) <= 2 ? 32'd1 : 32'd0);
    end
    chk("drain_rempty", 32'(rempty), 1);
    chk("drain_raddr", 32'(raddr), 5);
    chk("drain_rptr", 32'(rptr), 32'b00111);

    // Underflow: rinc still high while empty.
    cyc();
    chk("uf_raddr", 32'(raddr), 5);
    chk("uf_set", 32'(runderflow), 32'(UfEn));
    rinc = 1'b0;
    cyc();
    chk("uf_hold", 32'(runderflow), 32'(UfEn));
    rclr_uf = 1'b1;
    cyc();
    chk("uf_clr", 32'(runderflow), 0);
    rinc = 1'b1;
    cyc();
    chk("uf_set_wins", 32'(runderflow), 32'(UfEn));
    rinc = 1'b0;
    cyc();
    chk("uf_clr2", 32'(runderflow), 0);
    rclr_uf = 1'b0;

    // Bring the read count to 30.
    w_cnt = 30;
    cyc();
    rinc = 1'b1;
    for (int i = 0; i < 25; i++) cyc();
    chk("pre_wrap_raddr", 32'(raddr), 14);
    chk("pre_wrap_rempty", 32'(rempty), 1);

    // Wrap: write pointer at gray(1).
    rinc = 1'b0; w_cnt = 33;
    cyc();
    chk("wrap_rlevel", 32'(rlevel), 3);
    rinc = 1'b1;
    cyc();
    chk("wrap_rptr31", 32'(rptr), 32'b10000);
    cyc();
    chk("wrap_rptr0", 32'(rptr), 0);
    cyc();
    chk("wrap_rptr1", 32'(rptr), 32'b00001);
    chk("wrap_rempty", 32'(rempty), 1);
    chk("wrap_raddr", 32'(raddr), 1);

    // Threshold boundaries with a full FIFO (level 16).
    rinc = 1'b0; w_cnt = 49; rae_thresh = 5'd16;
    cyc();
    chk("full_rlevel", 32'(rlevel), 16);
    chk("th16_rae", 32'(ralmost_empty), 1);
    rae_thresh = 5'd15;
    cyc();
    chk("th15_rae", 32'(ralmost_empty), 0);
    rae_thresh = 5'd31;
    cyc();
    chk("th31_rae", 32'(ralmost_empty), 1);
    rae_thresh = 5'd0;
    cyc();
    chk("th0_rae", 32'(ralmost_empty), 0);

    // Concurrent reads and writes, then drain to empty with threshold 0.
    rinc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w_cnt = w_cnt + 1;
      cyc();
    end
    chk("rw_rlevel", 32'(rlevel), 16);
    for (int i = 0; i < 16; i++) cyc();
    chk("th0_empty_rempty", 32'(rempty), 1);
    chk("th0_empty_rae", 32'(ralmost_empty), 1);

    // Mid-operation reset after partial refill.
    rinc = 1'b0; w_cnt = w_cnt + 3;
    cyc();
    rrst = 1'b1; rinc = 1'b1; rclr_uf = 1'b0; w_cnt = 0;
    cyc();
    chk("rst2_raddr", 32'(raddr), 0);
    chk("rst2_rempty", 32'(rempty), 1);
    chk("rst2_rlevel", 32'(rlevel), 0);
    rrst = 1'b0; rinc = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
